// File: rtl/product_accumulator.sv
// product_accumulator: sums a frame of unsigned products (LEN of them, or fewer
// when in_last closes the frame early) and presents sum, count and a sticky
// overflow flag on a valid/ready result port. All outputs are registered.
module product_accumulator #(
    parameter  int PROD_W = 8,
    parameter  int ACC_W  = 16,
    parameter  int LEN    = 4,
    localparam int CNT_W  = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   sum_q;
    logic [CNT_W-1:0]   count_q;
    logic               ovfo_q;

    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               ovf_d;
    logic               accept;
    logic               frame_end;

    // Next accumulator value with carry-out, and frame termination decision.
    always_comb begin
        sum_ext   = {1'b0, acc_q} + (ACC_W + 1)'(in_prod);
        acc_d     = sum_ext[ACC_W-1:0];
        ovf_d     = ovf_q | sum_ext[ACC_W];
        cnt_d     = cnt_q + CNT_W'(1);
        accept    = in_valid & in_ready_q;
        frame_end = (cnt_q == CNT_W'(LEN - 1)) | in_last;
    end

    // Two-state frame FSM: accumulate in ST_ACC, present the result in ST_HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            count_q     <= '0;
            ovfo_q      <= 1'b0;
        end else if (state_q == ST_ACC) begin
            if (accept) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
                if (frame_end) begin
                    sum_q       <= acc_d;
                    count_q     <= cnt_d;
                    ovfo_q      <= ovf_d;
                    state_q     <= ST_HOLD;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                end
            end
        end else begin
            if (out_ready) begin
                acc_q       <= '0;
                cnt_q       <= '0;
                ovf_q       <= 1'b0;
                state_q     <= ST_ACC;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_ovf   = ovfo_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three builds (LEN=4/ACC_W=16, LEN=4/ACC_W=9,
// LEN=1/ACC_W=16) each with its own stimulus, checked against a frame-level
// arithmetic model (sum of products, count, total >= 2^ACC_W).
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       vld  [3];
    logic       lst  [3];
    logic       ordy [3];
    logic [7:0] prod [3];
    logic       irdy [3];
    logic       ovld [3];
    logic       oovf [3];

    logic [15:0] sum0, sum2;
    logic [8:0]  sum1;
    logic [2:0]  cnt0, cnt1;
    logic [0:0]  cnt2;

    int checks = 0;
    int errors = 0;

    product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(4)) u_main (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(irdy[0]), .in_prod(prod[0]),
        .in_last(lst[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .out_sum(sum0),
        .out_count(cnt0), .out_ovf(oovf[0]));

    product_accumulator #(.PROD_W(8), .ACC_W(9), .LEN(4)) u_ovf (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(irdy[1]), .in_prod(prod[1]),
        .in_last(lst[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .out_sum(sum1),
        .out_count(cnt1), .out_ovf(oovf[1]));

    product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(1)) u_len1 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(irdy[2]), .in_prod(prod[2]),
        .in_last(lst[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .out_sum(sum2),
        .out_count(cnt2), .out_ovf(oovf[2]));

    function automatic int acc_w_of(input int k);
        return (k == 1) ? 9 : 16;
    endfunction

    function automatic int len_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic logic [15:0] get_sum(input int k);
        case (k)
            0:       return sum0;
            1:       return {7'b0, sum1};
            default: return sum2;
        endcase
    endfunction

    function automatic logic [2:0] get_cnt(input int k);
        case (k)
            0:       return cnt0;
            1:       return cnt1;
            default: return {2'b0, cnt2};
        endcase
    endfunction

    // Present one product (called at a negedge) and return at the negedge after it is taken.
    task automatic send(input int k, input int p, input bit l);
        int n;
        vld[k]  = 1'b1;
        prod[k] = 8'(p);
        lst[k]  = l;
        n = 0;
        while (irdy[k] !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 40) begin
                checks++; errors++;
                $display("FAIL accept_timeout inst %0d in_ready=%b required 1", k, irdy[k]);
                vld[k] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Send a frame, check the result against the model, apply backpressure, release.
    // gap_mode: 0 back-to-back, 1 one idle cycle between products, 2 random 0..2 idle cycles.
    task automatic run_frame(input int k, input int ps[$], input bit ls[$],
                             input int gap_mode, input int bp, input bit hold_vld);
        int e, total, w, gap;
        logic [15:0] exp_sum;
        logic [2:0]  exp_cnt;
        logic        exp_ovf;
        w = acc_w_of(k);
        e = ps.size() - 1;
        total = 0;
        for (int i = 0; i < ps.size(); i++) begin
            total += ps[i];
            if (i + 1 == len_of(k) || ls[i]) begin
                e = i;
                break;
            end
        end
        exp_sum = 16'(total % (1 << w));
        exp_cnt = 3'(e + 1);
        exp_ovf = (total >= (1 << w));

        for (int i = 0; i <= e; i++) begin
            send(k, ps[i], ls[i]);
            if (i < e) begin
                checks++;
                if (ovld[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL early_valid inst %0d out_valid=%b required 0", k, ovld[k]);
                end
                gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                if (gap > 0) begin
                    vld[k] = 1'b0;
                    repeat (gap) begin
                        lst[k] = 1'($urandom_range(0, 1));
                        @(negedge clk);
                    end
                end
            end
        end

        if (hold_vld) begin
            vld[k]  = 1'b1;
            prod[k] = 8'($urandom_range(0, 255));
            lst[k]  = 1'b0;
        end else begin
            vld[k] = 1'b0;
        end

        checks++;
        if (ovld[k] !== 1'b1) begin
            errors++;
            $display("FAIL latency inst %0d out_valid=%b required 1", k, ovld[k]);
        end
        checks++;
        if (get_sum(k) !== exp_sum) begin
            errors++;
            $display("FAIL sum inst %0d got %0d required %0d", k, get_sum(k), exp_sum);
        end
        checks++;
        if (get_cnt(k) !== exp_cnt) begin
            errors++;
            $display("FAIL count inst %0d got %0d required %0d", k, get_cnt(k), exp_cnt);
        end
        checks++;
        if (oovf[k] !== exp_ovf) begin
            errors++;
            $display("FAIL ovf inst %0d got %b required %b", k, oovf[k], exp_ovf);
        end

        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            checks++;
            if (ovld[k] !== 1'b1 || irdy[k] !== 1'b0) begin
                errors++;
                $display("FAIL hold_handshake inst %0d out_valid=%b in_ready=%b required 1/0",
                         k, ovld[k], irdy[k]);
            end
            checks++;
            if (get_sum(k) !== exp_sum || get_cnt(k) !== exp_cnt || oovf[k] !== exp_ovf) begin
                errors++;
                $display("FAIL hold_stable inst %0d sum=%0d cnt=%0d ovf=%b required %0d/%0d/%b",
                         k, get_sum(k), get_cnt(k), oovf[k], exp_sum, exp_cnt, exp_ovf);
            end
        end

        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
        vld[k]  = 1'b0;
        checks++;
        if (ovld[k] !== 1'b0 || irdy[k] !== 1'b1) begin
            errors++;
            $display("FAIL release inst %0d out_valid=%b in_ready=%b required 0/1",
                     k, ovld[k], irdy[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ovld[k] !== 1'b0 || irdy[k] !== 1'b1 || get_sum(k) !== 16'd0 ||
                get_cnt(k) !== 3'd0 || oovf[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst %0d valid=%b ready=%b sum=%0d cnt=%0d ovf=%b required 0/1/0/0/0",
                         k, ovld[k], irdy[k], get_sum(k), get_cnt(k), oovf[k]);
            end
        end
    endtask

    task automatic test_full_frame();
        run_frame(0, '{225, 225, 225, 225}, '{0, 0, 0, 0}, 0, 0, 1'b0);
    endtask

    task automatic test_early_end();
        run_frame(0, '{6, 12}, '{0, 1}, 0, 0, 1'b0);
        run_frame(0, '{1, 1, 1, 1}, '{0, 0, 0, 0}, 0, 0, 1'b0);
        run_frame(0, '{5, 6, 7, 8}, '{0, 0, 0, 1}, 0, 0, 1'b0);
    endtask

    task automatic test_overflow();
        run_frame(1, '{225, 225, 225, 225}, '{0, 0, 0, 0}, 0, 0, 1'b0);
        run_frame(1, '{1, 2, 3, 4}, '{0, 0, 0, 0}, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame(0, '{100, 200, 3, 4}, '{0, 0, 0, 0}, 0, 5, 1'b1);
        run_frame(0, '{9, 8, 7, 6}, '{0, 0, 0, 0}, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        send(0, 50, 1'b0);
        send(0, 60, 1'b0);
        vld[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid inst 0 out_valid=%b in_ready=%b required 0/1", ovld[0], irdy[0]);
            end
            @(negedge clk);
        end
        run_frame(0, '{1, 1, 1, 1}, '{0, 0, 0, 0}, 0, 0, 1'b0);
    endtask

    task automatic test_gapped();
        run_frame(0, '{10, 20, 30, 40}, '{0, 0, 0, 0}, 1, 0, 1'b0);
        run_frame(2, '{7}, '{0}, 0, 0, 1'b0);
        run_frame(2, '{255}, '{1}, 0, 2, 1'b1);
    endtask

    task automatic test_random();
        int ps[$];
        bit ls[$];
        for (int f = 0; f < 12; f++) begin
            for (int k = 0; k < 3; k++) begin
                ps.delete();
                ls.delete();
                for (int i = 0; i < len_of(k); i++) begin
                    ps.push_back(int'($urandom_range(0, 255)));
                    ls.push_back($urandom_range(0, 3) == 0);
                end
                run_frame(k, ps, ls, 2, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            vld[k]  = 1'b0;
            lst[k]  = 1'b0;
            ordy[k] = 1'b0;
            prod[k] = 8'd0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_full_frame();
        test_early_end();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_gapped();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
